// File: rtl/uart_word_recv_if.sv
// Bus bundle between uart_word_recv, the uart_rx register reader it drives,
// and the word consumer that drains the packed-word FIFO.
interface uart_word_recv_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // uart_rx request/response side
    logic             rx_en;
    logic [3:0]       rx_addr;
    logic [7:0]       rx_data;
    logic             rx_busy;
    logic             rx_done;

    // packed-word consumer side
    logic             word_rd;
    logic [31:0]      word_data;
    logic             word_valid;
    logic [CNT_W-1:0] word_count;

    // The word receiver itself
    modport master (
        output rx_en, rx_addr,
        input  rx_data, rx_busy, rx_done,
        input  word_rd,
        output word_data, word_valid, word_count
    );

    // The environment around it (uart_rx plus the word consumer)
    modport slave (
        input  rx_en, rx_addr,
        output rx_data, rx_busy, rx_done,
        output word_rd,
        input  word_data, word_valid, word_count
    );
endinterface

// File: rtl/uart_word_recv.sv
// Polls the AXI UART Lite status register through uart_rx, reads one RX byte
// whenever the RX-valid bit is set, packs four bytes into a 32-bit word and
// queues the words in a first-word-fall-through FIFO for the core to drain.
module uart_word_recv #(
    parameter int         FIFO_DEPTH = 8,
    parameter bit         BIG_ENDIAN = 1'b1,
    parameter logic [3:0] STAT_ADDR  = 4'h8,
    parameter logic [3:0] RXF_ADDR   = 4'h0
) (
    input logic             clk,
    input logic             rst,
    uart_word_recv_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        STAT_REQ,
        STAT_WAIT,
        DATA_REQ,
        DATA_WAIT
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [1:0]    byte_cnt;
    logic [7:0]    byte0;
    logic [7:0]    byte1;
    logic [7:0]    byte2;
    logic          byte_wr;
    logic          push;
    logic          pop;
    logic [31:0]   word_in;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    // Byte order inside the word: first received byte is b0.
    function automatic logic [31:0] pack_word(input logic [7:0] b0,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2,
                                              input logic [7:0] b3);
        logic [31:0] w;
        if (BIG_ENDIAN) w = {b0, b1, b2, b3};
        else            w = {b3, b2, b1, b0};
        return w;
    endfunction

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign word_in = pack_word(byte0, byte1, byte2, bus.rx_data);
    assign pop     = bus.word_rd && !empty;

    // Request outputs decode straight from the state, so the address stays put
    // for the whole life of an outstanding read.
    assign bus.rx_en   = (state == STAT_REQ) || (state == DATA_REQ);
    assign bus.rx_addr = ((state == DATA_REQ) || (state == DATA_WAIT)) ? RXF_ADDR : STAT_ADDR;

    assign bus.word_data  = empty ? 32'd0 : mem[rd_ptr];
    assign bus.word_valid = !empty;
    assign bus.word_count = count;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; rx_done outside the two WAIT states is a stale
    // completion from before a reset and is deliberately ignored.
    always_comb begin
        state_nxt = state;
        byte_wr   = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                // Only the word-completing byte needs a free FIFO slot.
                if (!bus.rx_busy && ((byte_cnt != 2'd3) || !full))
                    state_nxt = STAT_REQ;
            end
            STAT_REQ: begin
                state_nxt = STAT_WAIT;
            end
            STAT_WAIT: begin
                if (bus.rx_done)
                    state_nxt = bus.rx_data[0] ? DATA_REQ : IDLE;
            end
            DATA_REQ: begin
                state_nxt = DATA_WAIT;
            end
            DATA_WAIT: begin
                if (bus.rx_done) begin
                    byte_wr   = 1'b1;
                    push      = (byte_cnt == 2'd3) && !full;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte slot counter; wraps 3 -> 0 as the word is pushed.
    always_ff @(posedge clk) begin
        if (rst)          byte_cnt <= 2'd0;
        else if (byte_wr) byte_cnt <= byte_cnt + 2'd1;
    end

    // Holding registers for the first three bytes; the fourth goes straight in.
    always_ff @(posedge clk) begin
        if (byte_wr) begin
            case (byte_cnt)
                2'd0:    byte0 <= bus.rx_data;
                2'd1:    byte1 <= bus.rx_data;
                2'd2:    byte2 <= bus.rx_data;
                default: ;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word_in;
    end
endmodule

// File: tb/tb_uart_word_recv.sv
// Bench for uart_word_recv: a big-endian and a little-endian instance run in
// lockstep on the same uart_rx model; packed words are checked from queues.
module tb_uart_word_recv;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_word_recv_if #(.FIFO_DEPTH(DEPTH)) be_if();
    uart_word_recv_if #(.FIFO_DEPTH(DEPTH)) le_if();

    uart_word_recv #(.FIFO_DEPTH(DEPTH), .BIG_ENDIAN(1'b1), .STAT_ADDR(4'h8), .RXF_ADDR(4'h0))
        dut_be (.clk(clk), .rst(rst), .bus(be_if));
    uart_word_recv #(.FIFO_DEPTH(DEPTH), .BIG_ENDIAN(1'b0), .STAT_ADDR(4'h8), .RXF_ADDR(4'h0))
        dut_le (.clk(clk), .rst(rst), .bus(le_if));

    assign le_if.rx_data = be_if.rx_data;
    assign le_if.rx_busy = be_if.rx_busy;
    assign le_if.rx_done = be_if.rx_done;
    assign le_if.word_rd = be_if.word_rd;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [7:0]  byte_q[$];
    logic [31:0] exp_be[$];
    logic [31:0] exp_le[$];

    int          lat = 2;
    int          stat_polls = 0;
    int          data_reads = 0;
    int          data_done = 0;
    bit          pending = 1'b0;
    bit          skip_addr_chk = 1'b0;
    logic [3:0]  pend_addr;
    int          lat_cnt;
    logic [7:0]  resp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic enq_word(input logic [31:0] w);
        byte_q.push_back(w[31:24]);
        byte_q.push_back(w[23:16]);
        byte_q.push_back(w[15:8]);
        byte_q.push_back(w[7:0]);
        exp_be.push_back(w);
        exp_le.push_back({w[7:0], w[15:8], w[23:16], w[31:24]});
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_valid"}, be_if.word_valid, 1'b1);
        check({tag, "_be"}, be_if.word_data, (exp_be.size() > 0) ? exp_be[0] : 32'hDEADBEEF);
        check({tag, "_le"}, le_if.word_data, (exp_le.size() > 0) ? exp_le[0] : 32'hDEADBEEF);
        be_if.word_rd = 1'b1;
        step();
        be_if.word_rd = 1'b0;
        if (exp_be.size() > 0) void'(exp_be.pop_front());
        if (exp_le.size() > 0) void'(exp_le.pop_front());
    endtask

    // uart_rx model: accepts a request, stays busy for lat cycles, then pulses done.
    initial begin
        be_if.rx_busy = 1'b0;
        be_if.rx_done = 1'b0;
        be_if.rx_data = 8'h00;
        forever begin
            @(negedge clk);
            be_if.rx_done = 1'b0;
            if (be_if.rx_en || le_if.rx_en) begin
                check("rx_en_lockstep", le_if.rx_en, be_if.rx_en);
                check("rx_en_while_busy", be_if.rx_busy, 1'b0);
            end
            if (pending) begin
                if (lat_cnt <= 1) begin
                    if (!skip_addr_chk) check("rx_addr_held", be_if.rx_addr, pend_addr);
                    be_if.rx_done = 1'b1;
                    be_if.rx_data = resp;
                    be_if.rx_busy = 1'b0;
                    pending = 1'b0;
                    if (pend_addr == 4'h0) data_done++;
                end else begin
                    lat_cnt--;
                end
            end else if (be_if.rx_en) begin
                pending = 1'b1;
                be_if.rx_busy = 1'b1;
                pend_addr = be_if.rx_addr;
                lat_cnt = lat;
                if (be_if.rx_addr == 4'h8) begin
                    stat_polls++;
                    resp = (byte_q.size() != 0) ? 8'h01 : 8'h00;
                end else begin
                    check("rx_addr_is_rxf", be_if.rx_addr, 4'h0);
                    check("rxf_read_nonempty", (byte_q.size() != 0), 1'b1);
                    data_reads++;
                    resp = (byte_q.size() != 0) ? byte_q.pop_front() : 8'hEE;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base_reads;
        int polls0;
        rst = 1'b1;
        be_if.word_rd = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_rx_en", be_if.rx_en, 1'b0);
        check("rst_rx_addr", be_if.rx_addr, 4'h8);
        check("rst_valid", be_if.word_valid, 1'b0);
        check("rst_count", be_if.word_count, 0);
        check("rst_data", be_if.word_data, 32'h0);
        check("rst_le_data", le_if.word_data, 32'h0);
        rst = 1'b0;

        // Empty UART: status polls only
        for (int i = 0; i < 400 && stat_polls < 10; i++) step();
        check("t1_polls", (stat_polls >= 10), 1'b1);
        check("t1_no_rxf", data_reads, 0);
        check("t1_valid", be_if.word_valid, 1'b0);

        // One word, both byte orders, push latency
        base = data_done;
        enq_word(32'h12345678);
        for (int i = 0; i < 400 && data_done < base + 4; i++) step();
        check("t2_4th_done", data_done, base + 4);
        check("t2_valid_same_cycle", be_if.word_valid, 1'b0);
        step();
        check("t2_valid_next", be_if.word_valid, 1'b1);
        check("t2_count", be_if.word_count, 1);
        check("t2_data_be", be_if.word_data, 32'h12345678);
        check("t3_data_le", le_if.word_data, 32'h78563412);
        pop_check("t2_pop");
        check("t2_count_after_pop", be_if.word_count, 0);

        // Fill the FIFO; the 9th word stalls after three bytes
        base = data_done;
        for (int k = 0; k < 9; k++) enq_word(32'hA0B0C0D0 + k * 32'h01010101);
        for (int i = 0; i < 3000 && data_done < base + 35; i++) step();
        repeat (30) step();
        check("t4_count_full", be_if.word_count, 8);
        check("t4_le_count_full", le_if.word_count, 8);
        check("t4_bytes_read", data_done, base + 35);
        check("t4_bytes_left", byte_q.size(), 1);
        polls0 = stat_polls;
        repeat (30) step();
        check("t4_stalled", stat_polls, polls0);
        pop_check("t4_pop");
        for (int i = 0; i < 400 && data_done < base + 36; i++) step();
        step();
        check("t4_9th_pushed", be_if.word_count, 8);
        check("t4_bytes_drained", byte_q.size(), 0);
        repeat (5) pop_check("t4_drain");
        check("t4_count3", be_if.word_count, 3);

        // Pop in the same cycle as a push at count 3
        base = data_done;
        enq_word(32'hCAFEF00D);
        for (int i = 0; i < 400 && data_done < base + 4; i++) step();
        check("t5_4th_done", data_done, base + 4);
        check("t5_head_be", be_if.word_data, exp_be[0]);
        be_if.word_rd = 1'b1;
        step();
        be_if.word_rd = 1'b0;
        void'(exp_be.pop_front());
        void'(exp_le.pop_front());
        check("t5_count_same", be_if.word_count, 3);
        check("t5_le_count_same", le_if.word_count, 3);
        repeat (3) pop_check("t5_order");
        check("t5_count_empty", be_if.word_count, 0);

        // Reset in DATA_WAIT after two bytes, stale done afterwards
        base = data_done;
        enq_word(32'h01020304);
        for (int i = 0; i < 400 && data_done < base + 4; i++) step();
        step();
        check("t6_word_before_rst", be_if.word_count, 1);
        lat = 8;
        skip_addr_chk = 1'b1;
        base_reads = data_reads;
        byte_q.push_back(8'hAA);
        byte_q.push_back(8'hBB);
        byte_q.push_back(8'hCC);
        for (int i = 0; i < 600 && data_reads < base_reads + 3; i++) step();
        check("t6_3rd_req", data_reads, base_reads + 3);
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_be.delete();
        exp_le.delete();
        check("t6_rst_count", be_if.word_count, 0);
        check("t6_rst_valid", be_if.word_valid, 1'b0);
        check("t6_rst_data", be_if.word_data, 32'h0);
        check("t6_done_pending", pending, 1'b1);
        lat = 2;
        for (int i = 0; i < 100 && pending; i++) step();
        skip_addr_chk = 1'b0;
        step();
        check("t6_stale_ignored", be_if.word_count, 0);
        enq_word(32'h55667788);
        for (int i = 0; i < 400 && !be_if.word_valid; i++) step();
        check("t6_clean_count", be_if.word_count, 1);
        pop_check("t6_clean");
        check("t6_empty_end", be_if.word_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
